// File: rtl/register_file_param_if.sv
// Register file bus: two read address/data pairs, one write port, ready flag.
// The master drives addresses and write data; the slave (register file) drives
// read data and o_Ready.
interface register_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] i_Read_Sel_1;
  logic [ADDR_W-1:0] i_Read_Sel_2;
  logic              i_Write_En;
  logic [ADDR_W-1:0] i_Write_Sel;
  logic [DATA_W-1:0] i_Write_Data;
  logic [DATA_W-1:0] o_Read_Data_1;
  logic [DATA_W-1:0] o_Read_Data_2;
  logic              o_Ready;

  modport master (
    output i_Read_Sel_1, i_Read_Sel_2, i_Write_En, i_Write_Sel, i_Write_Data,
    input  o_Read_Data_1, o_Read_Data_2, o_Ready
  );

  modport slave (
    input  i_Read_Sel_1, i_Read_Sel_2, i_Write_En, i_Write_Sel, i_Write_Data,
    output o_Read_Data_1, o_Read_Data_2, o_Ready
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised DEPTH x DATA_W register file: two combinational read ports,
// one synchronous write port, post-reset clear sequencer driving o_Ready.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forward).

// One read port: stored-data mux, optional forward, R0 zeroing, CLEAR gating.
module register_file_param_rd #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] i_Regs,
  input  logic [ADDR_W-1:0]                  i_Sel,
  input  logic                               i_Run,
  input  logic                               i_Fwd_Hit,
  input  logic [DATA_W-1:0]                  i_Fwd_Data,
  output logic [DATA_W-1:0]                  o_Data
);
  // Priority: CLEAR forces 0, then R0 zeroing, then forward, then storage.
  always_comb begin
    o_Data = '0;
    if (i_Run) begin
      o_Data = i_Fwd_Hit ? i_Fwd_Data : i_Regs[i_Sel];
      if (ZERO_R0 && (i_Sel == '0)) o_Data = '0;
    end
  end
endmodule

module register_file_param #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter bit                 ZERO_R0   = 1'b0
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  register_file_param_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                         r_state, w_state_nxt;
  logic [ADDR_W-1:0]              r_clr_cnt, w_clr_cnt_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]   r_regs;
  logic                           w_run;
  logic                           w_wr_ok;
  logic [NUM_RD-1:0][ADDR_W-1:0]  w_rd_sel;
  logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_data;
  logic [NUM_RD-1:0]              w_fwd_hit;

  assign w_run   = (r_state == RUN);
  // Writes to R0 are dropped outright when R0 is hardwired to zero.
  assign w_wr_ok = bus.i_Write_En && !(ZERO_R0 && (bus.i_Write_Sel == '0));

  // State register; reset restarts the clear walk at entry 0 from any state.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next state: walk every entry once in CLEAR, then stay in RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = RUN;
    end
  end

  // Storage: clear writes win in CLEAR (user writes dropped); user writes in RUN.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      if (!w_run)        r_regs[r_clr_cnt]       <= RESET_VAL;
      else if (w_wr_ok)  r_regs[bus.i_Write_Sel] <= bus.i_Write_Data;
    end
  end

  assign w_rd_sel = {bus.i_Read_Sel_2, bus.i_Read_Sel_1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      assign w_fwd_hit[gi] = bus.i_Write_En && (w_rd_sel[gi] == bus.i_Write_Sel);
`else
      assign w_fwd_hit[gi] = 1'b0;
`endif
      register_file_param_rd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ZERO_R0(ZERO_R0)
      ) u_rd (
        .i_Regs    (r_regs),
        .i_Sel     (w_rd_sel[gi]),
        .i_Run     (w_run),
        .i_Fwd_Hit (w_fwd_hit[gi]),
        .i_Fwd_Data(bus.i_Write_Data),
        .o_Data    (w_rd_data[gi])
      );
    end
  endgenerate

  assign bus.o_Read_Data_1 = w_rd_data[0];
  assign bus.o_Read_Data_2 = w_rd_data[1];
  assign bus.o_Ready       = w_run;
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: two instances (8x4 RESET_VAL=0x5A; 16x8
// RESET_VAL=0x1234 with R0 hardwired to zero), directed scenarios with literal
// expectations, then randomized traffic against an array-based model.
module tb_register_file_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus, held at the widest configuration.
  logic        rst [2];
  logic        we  [2];
  logic [2:0]  ws  [2];
  logic [2:0]  r1  [2];
  logic [2:0]  r2  [2];
  logic [15:0] wd  [2];
  logic [15:0] rd1 [2];
  logic [15:0] rd2 [2];
  logic        rdy [2];

  register_file_param_if #(.DATA_W(8),  .ADDR_W(2)) ifA();
  register_file_param_if #(.DATA_W(16), .ADDR_W(3)) ifB();

  assign ifA.i_Read_Sel_1 = r1[0][1:0];
  assign ifA.i_Read_Sel_2 = r2[0][1:0];
  assign ifA.i_Write_En   = we[0];
  assign ifA.i_Write_Sel  = ws[0][1:0];
  assign ifA.i_Write_Data = wd[0][7:0];
  assign rd1[0] = {8'h00, ifA.o_Read_Data_1};
  assign rd2[0] = {8'h00, ifA.o_Read_Data_2};
  assign rdy[0] = ifA.o_Ready;

  assign ifB.i_Read_Sel_1 = r1[1];
  assign ifB.i_Read_Sel_2 = r2[1];
  assign ifB.i_Write_En   = we[1];
  assign ifB.i_Write_Sel  = ws[1];
  assign ifB.i_Write_Data = wd[1];
  assign rd1[1] = ifB.o_Read_Data_1;
  assign rd2[1] = ifB.o_Read_Data_2;
  assign rdy[1] = ifB.o_Ready;

  register_file_param #(.DATA_W(8), .ADDR_W(2), .RESET_VAL(8'h5A), .ZERO_R0(1'b0)) dutA (
    .i_Clk(clk), .i_Rst(rst[0]), .bus(ifA));
  register_file_param #(.DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h1234), .ZERO_R0(1'b1)) dutB (
    .i_Clk(clk), .i_Rst(rst[1]), .bus(ifB));

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // since[k] counts clear edges completed after reset; the file is usable once
  // it reaches the entry count.
  logic [15:0] mem   [2][8];
  int          since [2];
  bit          seen  [2];

  function automatic int dep(input int k);  return (k == 0) ? 4 : 8; endfunction
  function automatic logic [15:0] rv(input int k); return (k == 0) ? 16'h005A : 16'h1234; endfunction

  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] s);
    if (since[k] < dep(k)) return 16'h0;
    if (k == 1 && s == 3'd0) return 16'h0;
    if (BYP && we[k] && ws[k] == s) return wd[k];
    return mem[k][s];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        since[k] <= 0;
        seen[k]  <= 1'b1;
      end else if (since[k] < dep(k)) begin
        mem[k][since[k]] <= rv(k);
        since[k]         <= since[k] + 1;
      end else if (we[k] && !(k == 1 && ws[k] == 3'd0)) begin
        mem[k][ws[k]] <= wd[k];
      end
    end
  end

  bit run_chk = 1'b1;
  always @(negedge clk) begin
    if (run_chk) begin
      for (int k = 0; k < 2; k++) begin
        if (seen[k]) begin
          chk($sformatf("m%0d_ready", k), {15'h0, rdy[k]}, {15'h0, since[k] >= dep(k)});
          chk($sformatf("m%0d_rd1", k), rd1[k], exp_rd(k, r1[k]));
          chk($sformatf("m%0d_rd2", k), rd2[k], exp_rd(k, r2[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic e, input logic [2:0] s,
                     input logic [15:0] d, input logic [2:0] a1, input logic [2:0] a2);
    we[k] = e; ws[k] = s; wd[k] = d; r1[k] = a1; r2[k] = a2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      seen[k] = 1'b0; since[k] = 0; rst[k] = 1'b1;
      drv(k, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    end
    // Reset held for three edges, then released.
    repeat (3) step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      @(negedge clk);
      if (e == 3) chk("A_ready_e3", {15'h0, rdy[0]}, 16'h0);
      if (e == 4) chk("A_ready_e4", {15'h0, rdy[0]}, 16'h1);
      if (e == 7) chk("B_ready_e7", {15'h0, rdy[1]}, 16'h0);
      if (e == 8) chk("B_ready_e8", {15'h0, rdy[1]}, 16'h1);
    end
    // All entries of A hold RESET_VAL.
    drv(0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1);
    drv(1, 1'b0, 3'd0, 16'h0, 3'd5, 3'd0);
    @(negedge clk);
    chk("A_R0_clr", rd1[0], 16'h005A);
    chk("A_R1_clr", rd2[0], 16'h005A);
    chk("B_R5_clr", rd1[1], 16'h1234);
    chk("B_R0_zero", rd2[1], 16'h0000);
    drv(0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd3);
    @(negedge clk);
    chk("A_R2_clr", rd1[0], 16'h005A);
    chk("A_R3_clr", rd2[0], 16'h005A);

    // Write R2=A5, then R3=3C; B: R0=00FF (dropped).
    step();
    drv(0, 1'b1, 3'd2, 16'h00A5, 3'd0, 3'd0);
    drv(1, 1'b1, 3'd0, 16'h00FF, 3'd0, 3'd0);
    step();
    drv(0, 1'b1, 3'd3, 16'h003C, 3'd2, 3'd2);
    drv(1, 1'b1, 3'd1, 16'h00FF, 3'd0, 3'd0);
    @(negedge clk);
    chk("A_R2_wr", rd1[0], 16'h00A5);
    chk("B_R0_wr_drop", rd1[1], 16'h0000);
    step();
    drv(0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd2);
    drv(1, 1'b1, 3'd7, 16'hBEEF, 3'd1, 3'd1);
    @(negedge clk);
    chk("A_R3_wr", rd1[0], 16'h003C);
    chk("A_R2_keep", rd2[0], 16'h00A5);
    chk("B_R1_wr", rd1[1], 16'h00FF);
    step();
    drv(0, 1'b1, 3'd1, 16'h0077, 3'd1, 3'd1);
    drv(1, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7);
    @(negedge clk);
    chk("A_R1_same_cyc", rd1[0], BYP ? 16'h0077 : 16'h005A);
    chk("B_R7_p1", rd1[1], 16'hBEEF);
    chk("B_R7_p2", rd2[1], 16'hBEEF);
    step();
    drv(0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2);
    @(negedge clk);
    chk("A_R1_next", rd1[0], 16'h0077);

    // Reset interrupted after two clear edges; a write to R0 during CLEAR is dropped.
    rst[0] = 1'b1; step();
    rst[0] = 1'b0; step(); step();
    rst[0] = 1'b1; step();
    rst[0] = 1'b0;
    drv(0, 1'b1, 3'd0, 16'h00EE, 3'd0, 3'd0);
    for (int e = 1; e <= 4; e++) begin
      step();
      @(negedge clk);
      if (e == 3) chk("A_rerst_e3", {15'h0, rdy[0]}, 16'h0);
      if (e == 4) chk("A_rerst_e4", {15'h0, rdy[0]}, 16'h1);
    end
    drv(0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1);
    @(negedge clk);
    chk("A_R0_clr_wr_drop", rd1[0], 16'h005A);
    chk("A_R1_reclr", rd2[0], 16'h005A);

    // Randomized traffic, occasional resets (including mid-clear).
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        rst[k] = ($urandom_range(0, 79) == 0);
        drv(k, 1'(($urandom_range(0, 2)) != 0),
               3'($urandom_range(0, dep(k) - 1)),
               (k == 0) ? {8'h00, 8'($urandom)} : 16'($urandom),
               3'($urandom_range(0, dep(k) - 1)),
               3'($urandom_range(0, dep(k) - 1)));
      end
    end
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (10) step();
    @(negedge clk);
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
